// File: rtl/mips_pkg.sv
// Shared MIPS pipeline package: MEM-stage state encoding, datapath widths and ALU-op codes.
package mips_pkg;

  localparam int MIPS_DATA_W      = 32;
  localparam int MIPS_REG_AW      = 5;
  localparam int MIPS_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_MEM  = 2'd1,
    MS_WB   = 2'd2
  } ms_state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_NOR = 4'd5
  } alu_op_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Memory wait-state watchdog: 8-bit counter held clear outside MEM, flags expiry on the LIMIT-th cycle.
// Only compiled when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired
);

  logic [7:0] cnt_q;

  // cnt_q holds (cycles spent in MEM - 1), so the compare is against LIMIT-1
  assign expired = (cnt_q == 8'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/mem_access_stage.sv
// MEM stage: captures EX results, resolves beq, runs the dmem req/ack handshake, emits one writeback beat.
// Optional MEM_TIMEOUT_EN adds a watchdog that abandons an unacknowledged access.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int DATA_W      = MIPS_DATA_W,
  parameter int REG_AW      = MIPS_REG_AW,
  parameter int TIMEOUT_CYC = MIPS_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              branch,
  input  logic [DATA_W-1:0] br_target_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic              misalign_err,
  output ms_state_e         dbg_state
);

  // Handshake: EX transfers an instruction on a cycle where ex_valid & ex_ready are both high;
  // dmem_req rises the cycle after a memory accept and holds addr/we/wdata until the dmem_ack cycle.
  ms_state_e         state_q, state_d;
  logic              accept, is_mem, misaligned, go_mem, br_hit, timeout;
  logic              rw_q, ld_q, we_q, err_q, br_taken_q;
  logic [REG_AW-1:0] wb_reg_q;
  logic [DATA_W-1:0] wb_data_q, addr_q, wdata_q, br_target_q;

  assign ex_ready   = (state_q == MS_IDLE) || (state_q == MS_WB);
  assign accept     = ex_valid & ex_ready;
  assign is_mem     = mem_read | mem_write;
  assign misaligned = is_mem & (alu_out[1:0] != 2'b00);
  assign go_mem     = is_mem & ~misaligned;
  assign br_hit     = accept & branch & alu_zero;

`ifdef MEM_TIMEOUT_EN
  logic tmo_expired;

  mem_timeout_ctr #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != MS_MEM),
    .expired (tmo_expired)
  );

  // A same-cycle ack takes priority over expiry
  assign timeout = (state_q == MS_MEM) & tmo_expired & ~dmem_ack;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MS_IDLE, MS_WB: begin
        if (accept) state_d = go_mem ? MS_MEM : MS_WB;
        else        state_d = MS_IDLE;
      end
      MS_MEM: begin
        if (dmem_ack || timeout) state_d = MS_WB;
      end
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q        <= 1'b0;
      ld_q        <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      br_taken_q  <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      br_target_q <= '0;
    end else begin
      br_taken_q  <= br_hit;
      br_target_q <= br_hit ? br_target_in : '0;
      err_q       <= (accept & misaligned) | timeout;
      if (accept) begin
        wb_reg_q  <= dest_reg;
        wb_data_q <= alu_out;
        // Stores (including the read+write combination) and faulted accesses never write back
        rw_q      <= reg_write & ~mem_write & ~misaligned;
        ld_q      <= mem_read & ~mem_write;
        we_q      <= mem_write;
        addr_q    <= {alu_out[DATA_W-1:2], 2'b00};
        wdata_q   <= store_data;
      end else if (state_q == MS_MEM) begin
        if (dmem_ack && ld_q) wb_data_q <= dmem_rdata;
        if (timeout)          rw_q      <= 1'b0;
      end
    end
  end

  assign dmem_req     = (state_q == MS_MEM);
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = (state_q == MS_WB);
  assign wb_reg_write = wb_valid & rw_q;
  assign wb_reg       = wb_reg_q;
  assign wb_data      = wb_data_q;
  assign br_taken     = br_taken_q;
  assign br_target    = br_target_q;
  assign misalign_err = err_q;
  assign dbg_state    = state_q;

endmodule
